// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant owner, latency counter width.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision for the unified memory: data first, except when the fetch side has waited
// through STARVE_LIMIT consecutive data grants. Combinational grant, registered streak.
module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);
  import unified_mem_arbiter_pkg::*;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak;
  logic          starve;

  always_comb begin
    starve   = (STARVE_LIMIT != 0) && (streak == LIMIT) && if_req;
    grant_dm = arb_en && dm_req && !starve;
    grant_if = arb_en && if_req && !grant_dm;
  end

  // Streak only counts data grants that actually made a fetch wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_dm) begin
      if (!if_req)
        streak <= '0;
      else if (streak != LIMIT)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access per
// MEM_LAT+3 cycles; requesters see stall until their one-cycle valid pulse.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import unified_mem_arbiter_pkg::*;

  state_t           state;
  owner_t           owner;
  logic [LAT_W-1:0] lat_cnt;
  logic             arb_en;
  logic             grant_if;
  logic             grant_dm;

  assign arb_en   = (state == IDLE);
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state     <= WAIT;
            owner     <= OWN_DM;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            lat_cnt   <= LAT_W'(MEM_LAT);
          end else if (grant_if) begin
            state     <= WAIT;
            owner     <= OWN_IF;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            lat_cnt   <= LAT_W'(MEM_LAT);
          end
        end
        WAIT: begin
          // Counter reaches zero in the cycle mem_rdata is valid.
          if (lat_cnt == '0) begin
            state <= RESP;
            if (owner == OWN_DM) begin
              dm_valid <= 1'b1;
              if (!mem_we)
                dm_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each memory access with a fixed latency and returns the read data.
- Produces per-requester stall signals that the pipeline ORs into its PC/IF_ID hold logic.
- Data requests have priority; a streak counter prevents fetch starvation.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid; legal range 1..15.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; 0 = strict data priority.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_valid.
- dm_req  in  1  data request, level.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle data completion pulse (loads and stores).
- dm_stall  out  1  dm_req & ~dm_valid.
- mem_en  out  1  memory access strobe, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. On reset, state=IDLE and all registered outputs are 0, including mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid and the streak counter. A reset mid-access abandons the access; any later mem_rdata is ignored.

- States:
  - IDLE: sample requests and grant one requester.
  - WAIT: the latency counter runs.
  - RESP: pulse valid to the granted requester.

- Grant rule in IDLE:
  - If dm_req=1 and not (STARVE_LIMIT≠0 and streak==STARVE_LIMIT and if_req=1): grant DM.
  - Else if if_req=1: grant IF.
  - Else: stay in IDLE.

- Streak counter:
  - Increments on each DM grant made while if_req=1.
  - Clears on any IF grant.
  - Clears on a DM grant made while if_req=0.
  - Saturates at STARVE_LIMIT.

- Timing, with requests sampled in IDLE at cycle T:
  - T+1, state WAIT: mem_en=1 for exactly one cycle. mem_addr, mem_we and mem_wdata come from the granted requester (mem_we=0 for IF) and are held until the next grant. Counter is loaded with MEM_LAT.
  - Cycles T+2..T+MEM_LAT+1: counter decrements.
  - T+MEM_LAT+1: mem_rdata valid. For a read, it is captured into the granted requester's rdata register. Stores leave dm_rdata unchanged.
  - T+MEM_LAT+2, state RESP: granted requester's valid=1 for one cycle. Requests are ignored in RESP.
  - T+MEM_LAT+3: state IDLE; arbitration resumes.

- Throughput: one access per MEM_LAT+3 cycles. A requester holding req high across its valid cycle gets a fresh access at the next IDLE.
- Stall outputs are combinational from req and the registered valid only. No other combinational path from inputs to outputs.
- Address and write data are latched at grant. Changes to inputs after grant are ignored.
- A requester dropping req before valid is a protocol violation. The access still completes and valid still pulses.
- Simultaneous requests at IDLE follow the grant rule; the loser keeps its stall high throughout.
- rdata registers hold their value until the next read completion for that requester.

Decomposition:
- Package unified_mem_arbiter_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Grant-owner encoding {OWN_IF, OWN_DM}.
  - Latency counter width constant LAT_W=4.
- Sub-module mem_arb_grant: combinational grant decision plus the streak counter register (inputs if_req, dm_req, arbitrate enable; outputs grant_if, grant_dm).

Test Plan:
- Reset: rst=1 mid-WAIT with dm_req=1 → next cycle mem_en=0, dm_valid=0, dm_rdata=0, state IDLE; after release with MEM_LAT=1, a new grant at T gives dm_valid at T+3.
- Lone fetch: MEM_LAT=2, if_req=1, if_addr=0x10, mem returns 0x00500093 → mem_en at T+1 with mem_addr=0x10; if_valid at T+4 with if_rdata=0x00500093; if_stall high T..T+3.
- Store: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF → mem_we=1 and mem_wdata=0xDEADBEEF in the mem_en cycle; dm_valid pulses; dm_rdata unchanged.
- Simultaneous requests: if_req and dm_req both high in the same IDLE cycle → DM served first, IF served at the next IDLE, if_stall high throughout.
- Starvation: STARVE_LIMIT=2, if_req and dm_req held high continuously → grant order DM, DM, IF, DM, DM, IF.
- Strict priority: STARVE_LIMIT=0 with the same stimulus → DM-only grants, if_valid never asserts.
